pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Frame-paced game sequencer for the pong design. It sits between the sync-pulse generator and the pong datapath and runs the match: start, serve delay, rally, point pause and game over. It gates paddle and ball motion, holds the ball at centre between rallies, picks the serve direction and keeps both scores.

## Interface
Parameters:
- SERVE_FRAMES, 60: frames the ball is held at centre before launch.
- POINT_FRAMES, 30: frames frozen after a point.
- WIN_SCORE, 7: score that ends the match; must be < 2^SCORE_W.
- SCORE_W, 4: score counter width.
- ATTRACT_FRAMES, 600: idle frames before demo mode (used only under GAME_CTRL_ATTRACT_EN).

Ports:
- clk  in  1  pixel clock, the only clock.
- rst_n  in  1  asynchronous active-low reset.
- v_sync  in  1  vertical sync level from the sync generator; a rising edge marks one frame.
- start  in  1  start button, already synchronous to clk, level.
- miss_l  in  1  one-cycle pulse: ball passed the left paddle, so the right player scores.
- miss_r  in  1  one-cycle pulse: ball passed the right paddle, so the left player scores.
- paddle_en  out  1  paddles may move.
- ball_en  out  1  ball may move.
- ball_reset  out  1  hold ball at screen centre.
- serve_dir  out  1  launch direction: 0 = leftward, 1 = rightward.
- score_l  out  SCORE_W  left score.
- score_r  out  SCORE_W  right score.
- game_over  out  1  match finished.
- winner  out  1  0 = left, 1 = right; valid while game_over is high.
- force_ai  out  1  both paddles under AI control (demo mode).

## Operation
Frame tick and start edge:
- frame_tick is high for exactly one cycle, on the cycle after v_sync is first seen high (registered previous value, rising-edge detect).
- start_rise is the rising edge of start, using a registered previous value.
- Frame counter fc clears on every state entry and increments on each frame_tick.

States:
- IDLE: scores held at 0, ball_reset=1, ball_en=0, paddle_en=0. start_rise → SERVE.
- SERVE: paddle_en=1, ball_reset=1, ball_en=0. When fc==SERVE_FRAMES-1 and frame_tick is high → PLAY.
- PLAY: paddle_en=1, ball_en=1, ball_reset=0.
  - miss_l alone: score_r+1, serve_dir←0, → POINT.
  - miss_r alone: score_l+1, serve_dir←1, → POINT.
  - miss_l and miss_r in the same cycle: no score change, serve_dir unchanged, → SERVE.
- POINT: paddle_en=0, ball_en=0, ball_reset=0, so the ball stays frozen where it left play.
  - After POINT_FRAMES ticks: → OVER if either score == WIN_SCORE, else → SERVE.
- OVER: game_over=1, winner = the side at WIN_SCORE, ball_reset=1, all enables 0. start_rise → IDLE, clearing scores, game_over and winner.

Boundary rules:
- miss_l and miss_r outside PLAY are ignored.
- start_rise outside IDLE and OVER is ignored.
- A score never exceeds WIN_SCORE.
- rst_n low at any point returns the block to its reset state immediately; any count in progress is lost.

## Timing
Reset values:
- State IDLE; score_l=0, score_r=0.
- serve_dir=1, ball_reset=1.
- paddle_en=0, ball_en=0, game_over=0, winner=0, force_ai=0.

Latency:
- All outputs are registered, derived from the next state.
- A miss pulse in cycle N gives an updated score and ball_en=0 in cycle N+1.
- start_rise in cycle N gives paddle_en=1 in cycle N+1.
- SERVE lasts exactly SERVE_FRAMES frame_ticks and POINT lasts exactly POINT_FRAMES; a state is never left on a non-tick cycle.

## Configuration
GAME_CTRL_ATTRACT_EN:
- Defined: in IDLE, after ATTRACT_FRAMES ticks with no start_rise, enter SERVE with force_ai=1 (demo mode).
  - In demo mode, start_rise in any state returns to IDLE with scores cleared and force_ai=0.
  - A demo match reaching OVER returns to IDLE after POINT_FRAMES ticks.
- Undefined: force_ai is tied to 0, there is no idle timeout, and IDLE waits for start_rise only.

## Test plan
- Reset mid-SERVE (fc=20) → all outputs at their reset values, state IDLE, fc=0.
- start pulse, SERVE_FRAMES=3 → ball_en rises on the cycle after the 3rd frame_tick; ball_reset falls on that same cycle.
- In PLAY, miss_r pulse → score_l=1, serve_dir=1, and ball_en=0 on the next cycle; SERVE resumes after POINT_FRAMES ticks.
- miss_l and miss_r in the same cycle during PLAY → scores unchanged, next state SERVE.
- score_r=6 with WIN_SCORE=7, then miss_l → score_r=7; after POINT, game_over=1 and winner=1. start → IDLE with scores 0.
- With GAME_CTRL_ATTRACT_EN and ATTRACT_FRAMES=5, no start → force_ai=1 after the 5th tick; a start pulse then gives force_ai=0 and IDLE.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-paced match sequencer (start, serve, rally, point pause, game over)
// Optional demo mode is compiled in with GAME_CTRL_ATTRACT_EN.
// Ports: clk pixel clock; rst_n asynchronous active-low reset;
//        v_sync vertical sync level (rising edge = one frame); start button level;
//        miss_l / miss_r one-cycle miss pulses (right / left player scores);
//        paddle_en, ball_en, ball_reset motion gating; serve_dir launch direction (1 = rightward);
//        score_l, score_r scores; game_over, winner (1 = right); force_ai demo mode.
module pong_game_ctrl #(
   parameter int SERVE_FRAMES   = 60,
   parameter int POINT_FRAMES   = 30,
   parameter int WIN_SCORE      = 7,
   parameter int SCORE_W        = 4,
   parameter int ATTRACT_FRAMES = 600
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               v_sync,
   input  logic               start,
   input  logic               miss_l,
   input  logic               miss_r,
   output logic               paddle_en,
   output logic               ball_en,
   output logic               ball_reset,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               game_over,
   output logic               winner,
   output logic               force_ai
);
   localparam int FC_MAX0 = SERVE_FRAMES > POINT_FRAMES ? SERVE_FRAMES : POINT_FRAMES;
   localparam int FC_MAX  = FC_MAX0 > ATTRACT_FRAMES ? FC_MAX0 : ATTRACT_FRAMES;
   localparam int FC_W    = FC_MAX < 2 ? 1 : $clog2(FC_MAX);
   localparam logic [FC_W-1:0]    SERVE_LAST = FC_W'(SERVE_FRAMES - 1);
   localparam logic [FC_W-1:0]    POINT_LAST = FC_W'(POINT_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

   typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

   state_t             state, state_n;
   logic [FC_W-1:0]    fc, fc_n;
   logic [SCORE_W-1:0] score_l_n, score_r_n;
   logic               serve_dir_n, vs_q, frame_tick, start_q, start_rise;
   logic               paddle_d, ball_d, ball_reset_d, game_over_d, winner_d;

   assign start_rise = start & ~start_q;

   // frame_tick is registered, so it is high the cycle after v_sync is first sampled high
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         fc         <= '0;
         vs_q       <= 1'b0;
         frame_tick <= 1'b0;
         start_q    <= 1'b0;
         score_l    <= '0;
         score_r    <= '0;
         serve_dir  <= 1'b1;
         paddle_en  <= 1'b0;
         ball_en    <= 1'b0;
         ball_reset <= 1'b1;
         game_over  <= 1'b0;
         winner     <= 1'b0;
      end else begin
         state      <= state_n;
         fc         <= fc_n;
         vs_q       <= v_sync;
         frame_tick <= v_sync & ~vs_q;
         start_q    <= start;
         score_l    <= score_l_n;
         score_r    <= score_r_n;
         serve_dir  <= serve_dir_n;
         paddle_en  <= paddle_d;
         ball_en    <= ball_d;
         ball_reset <= ball_reset_d;
         game_over  <= game_over_d;
         winner     <= winner_d;
      end

`ifdef GAME_CTRL_ATTRACT_EN
   localparam logic [FC_W-1:0] ATTRACT_LAST = FC_W'(ATTRACT_FRAMES - 1);
   logic demo_n;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) force_ai <= 1'b0;
      else        force_ai <= demo_n;
`else
   assign force_ai = 1'b0;
`endif

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start_rise) state_n = SERVE;
         SERVE:   if (frame_tick && fc == SERVE_LAST) state_n = PLAY;
         PLAY:    if (miss_l && miss_r) state_n = SERVE;
                  else if (miss_l || miss_r) state_n = POINT;
         POINT:   if (frame_tick && fc == POINT_LAST)
                     state_n = (score_l == WIN || score_r == WIN) ? OVER : SERVE;
         OVER:    if (start_rise) state_n = IDLE;
         default: state_n = IDLE;
      endcase
`ifdef GAME_CTRL_ATTRACT_EN
      demo_n = force_ai;
      if (state == IDLE && !start_rise && frame_tick && fc == ATTRACT_LAST) begin
         state_n = SERVE;
         demo_n  = 1'b1;
      end
      if (force_ai && (start_rise || (state == OVER && frame_tick && fc == POINT_LAST)))
         state_n = IDLE;
      if (state_n == IDLE) demo_n = 1'b0;
`endif
      fc_n        = state_n != state ? '0 : fc + FC_W'(frame_tick);
      // a double miss is a wash: no score, no direction change
      score_l_n   = state_n == IDLE ? '0
                  : (state == PLAY && miss_r && !miss_l && score_l != WIN) ? score_l + 1'b1 : score_l;
      score_r_n   = state_n == IDLE ? '0
                  : (state == PLAY && miss_l && !miss_r && score_r != WIN) ? score_r + 1'b1 : score_r;
      serve_dir_n = (state == PLAY && miss_l != miss_r) ? miss_r : serve_dir;
   end

   always_comb begin
      paddle_d     = state_n == SERVE || state_n == PLAY;
      ball_d       = state_n == PLAY;
      ball_reset_d = state_n == IDLE || state_n == SERVE || state_n == OVER;
      game_over_d  = state_n == OVER;
      winner_d     = state_n == OVER && score_r_n == WIN;
   end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed vector bench for pong_game_ctrl
module tb_pong_game_ctrl;
   localparam int SW = 4;
   // flags = {paddle_en, ball_en, ball_reset, serve_dir, game_over, winner, force_ai}
   localparam logic [6:0] I1 = 7'b0011000, I0 = 7'b0010000;
   localparam logic [6:0] S1 = 7'b1011000, S0 = 7'b1010000;
   localparam logic [6:0] P1 = 7'b1101000, P0 = 7'b1100000;
   localparam logic [6:0] T1 = 7'b0001000, T0 = 7'b0000000;
   localparam logic [6:0] OV = 7'b0010110, DEMO = 7'b1011001;

   logic clk = 1'b0, rst_n = 1'b0, v_sync = 1'b0, start = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
   logic paddle_en, ball_en, ball_reset, serve_dir, game_over, winner, force_ai;
   logic [SW-1:0] score_l, score_r;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   pong_game_ctrl #(
      .SERVE_FRAMES(3), .POINT_FRAMES(2), .WIN_SCORE(7), .SCORE_W(SW), .ATTRACT_FRAMES(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .v_sync(v_sync), .start(start), .miss_l(miss_l), .miss_r(miss_r),
      .paddle_en(paddle_en), .ball_en(ball_en), .ball_reset(ball_reset), .serve_dir(serve_dir),
      .score_l(score_l), .score_r(score_r), .game_over(game_over), .winner(winner),
      .force_ai(force_ai)
   );

   typedef struct {
      logic v, s, ml, mr;
      logic [6:0] f;
      logic [SW-1:0] l, r;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(logic v, s, ml, mr, logic [6:0] f, logic [SW-1:0] l, r);
      vec_t x;
      x.v = v; x.s = s; x.ml = ml; x.mr = mr; x.f = f; x.l = l; x.r = r;
      return x;
   endfunction

   task automatic check(string name, logic [6:0] f, logic [SW-1:0] l, r);
      logic [6:0] af;
      af = {paddle_en, ball_en, ball_reset, serve_dir, game_over, winner, force_ai};
      checks++;
      if ({af, score_l, score_r} !== {f, l, r}) begin
         errors++;
         $display("FAIL %s: got flags=%b l=%0d r=%0d, want flags=%b l=%0d r=%0d",
                  name, af, score_l, score_r, f, l, r);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      v_sync = 1'b1; cyc();
      v_sync = 1'b0; cyc();
   endtask

   task automatic miss(input logic l, r);
      miss_l = l; miss_r = r; cyc();
      miss_l = 1'b0; miss_r = 1'b0;
   endtask

   task automatic press();
      start = 1'b1; cyc();
      start = 1'b0;
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      // start, serve of 3 frames, point for left, ignored inputs, double miss, point for right
      tbl.push_back(mk(0,0,0,0, I1, 0, 0));
      tbl.push_back(mk(0,1,0,0, S1, 0, 0));
      tbl.push_back(mk(1,0,0,0, S1, 0, 0));
      tbl.push_back(mk(0,0,0,0, S1, 0, 0));
      tbl.push_back(mk(1,0,0,0, S1, 0, 0));
      tbl.push_back(mk(0,0,0,0, S1, 0, 0));
      tbl.push_back(mk(1,0,0,0, S1, 0, 0));
      tbl.push_back(mk(0,0,0,0, P1, 0, 0));
      tbl.push_back(mk(0,0,0,1, T1, 1, 0));
      tbl.push_back(mk(1,0,0,0, T1, 1, 0));
      tbl.push_back(mk(0,0,0,0, T1, 1, 0));
      tbl.push_back(mk(1,0,1,0, T1, 1, 0));
      tbl.push_back(mk(0,0,0,0, S1, 1, 0));
      tbl.push_back(mk(0,1,0,0, S1, 1, 0));
      tbl.push_back(mk(1,0,0,0, S1, 1, 0));
      tbl.push_back(mk(0,0,0,0, S1, 1, 0));
      tbl.push_back(mk(1,0,0,0, S1, 1, 0));
      tbl.push_back(mk(0,0,0,0, S1, 1, 0));
      tbl.push_back(mk(1,0,0,0, S1, 1, 0));
      tbl.push_back(mk(0,0,0,0, P1, 1, 0));
      tbl.push_back(mk(0,0,1,1, S1, 1, 0));
      tbl.push_back(mk(1,0,0,0, S1, 1, 0));
      tbl.push_back(mk(0,0,0,0, S1, 1, 0));
      tbl.push_back(mk(1,0,0,0, S1, 1, 0));
      tbl.push_back(mk(0,0,0,0, S1, 1, 0));
      tbl.push_back(mk(1,0,0,0, S1, 1, 0));
      tbl.push_back(mk(0,0,0,0, P1, 1, 0));
      tbl.push_back(mk(0,0,1,0, T0, 1, 1));
      tbl.push_back(mk(1,0,0,0, T0, 1, 1));
      tbl.push_back(mk(0,0,0,0, T0, 1, 1));
      tbl.push_back(mk(1,0,0,0, T0, 1, 1));
      tbl.push_back(mk(0,0,0,0, S0, 1, 1));

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      foreach (tbl[i]) begin
         v_sync = tbl[i].v; start = tbl[i].s; miss_l = tbl[i].ml; miss_r = tbl[i].mr;
         cyc();
         check($sformatf("vec%0d", i), tbl[i].f, tbl[i].l, tbl[i].r);
      end
      v_sync = 1'b0; start = 1'b0; miss_l = 1'b0; miss_r = 1'b0;

      // reset part-way through a serve: everything back to reset values at once
      frame(); frame();
      check("serve_mid", S0, 1, 1);
      #1 rst_n = 1'b0;
      #1 check("async_reset", I1, 0, 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      check("after_reset", I1, 0, 0);
      press();
      check("start_serve", S1, 0, 0);
      frame(); frame();
      check("serve_2_ticks", S1, 0, 0);
      frame();
      check("serve_3_ticks", P1, 0, 0);

      // right player wins 7-0
      for (int i = 1; i <= 7; i++) begin
         miss(1'b1, 1'b0);
         check($sformatf("point_r%0d", i), T0, 0, SW'(i));
         frame(); frame();
         if (i < 7) begin
            check($sformatf("reserve%0d", i), S0, 0, SW'(i));
            frame(); frame(); frame();
         end
      end
      check("game_over", OV, 0, 7);
      miss(1'b0, 1'b1);
      frame();
      check("over_ignores_miss", OV, 0, 7);
      press();
      check("over_to_idle", I0, 0, 0);

      // idle with no start: demo mode after 5 ticks only when compiled in
      do_reset();
      for (int i = 1; i <= 4; i++) frame();
      check("idle_4_ticks", I1, 0, 0);
      frame();
`ifdef GAME_CTRL_ATTRACT_EN
      check("attract_entry", DEMO, 0, 0);
      frame();
      press();
      check("attract_exit", I1, 0, 0);
`else
      check("idle_5_ticks", I1, 0, 0);
      frame();
      check("idle_6_ticks", I1, 0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
